// File: rtl/memory_sdp_be.sv
// Simple dual-port SRAM with per-byte write enables, 1-cycle registered read and a
// sequential zeroing sweep after reset. Optional per-byte parity: define MEM_PARITY_EN.
module memory_sdp_be #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [WIDTH/8-1:0]    wr_be_i,
  input  logic                  par_inj_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  perr_o
);

  localparam int unsigned BE_W = WIDTH / 8;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    init_busy_q;
  logic                    rd_valid_q;
  logic [WIDTH-1:0]        rd_data_q;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic                    wr_ok;
  logic                    rd_ok;
  logic                    init_last;

  assign wr_ok     = 32'(wr_addr_i) < DEPTH;
  assign rd_ok     = 32'(rd_addr_i) < DEPTH;
  assign init_last = 32'(init_cnt_q) == (DEPTH - 1);

`ifdef MEM_PARITY_EN
  logic [BE_W-1:0]  par_mem [DEPTH];
  logic [WIDTH-1:0] rd_word_c;
  logic [BE_W-1:0]  rd_calc_par_c;
  logic             rd_mismatch_c;
  logic             perr_q;

  // Recompute even parity of the addressed word and compare against the stored bits.
  always_comb begin
    rd_word_c     = mem[rd_addr_i];
    rd_calc_par_c = '0;
    for (int b = 0; b < int'(BE_W); b++) begin
      rd_calc_par_c[b] = ^rd_word_c[8*b +: 8];
    end
    rd_mismatch_c = |(rd_calc_par_c ^ par_mem[rd_addr_i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
    end else if (state_q == ST_READY && rd_en_i) begin
      perr_q <= rd_ok && rd_mismatch_c;
    end else begin
      perr_q <= 1'b0;
    end
  end

  assign perr_o = perr_q;
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj_i;
  assign perr_o         = 1'b0;
`endif

  // Control FSM: zeroing sweep, then serve reads at one per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
          if (init_last) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        ST_READY: begin
          if (rd_en_i) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_ok ? mem[rd_addr_i] : '0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Storage array; read-first falls out of the non-blocking update.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) begin
        mem[init_cnt_q] <= '0;
`ifdef MEM_PARITY_EN
        par_mem[init_cnt_q] <= '0;
`endif
      end else if (wr_en_i && wr_ok) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (wr_be_i[b]) begin
            mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
`ifdef MEM_PARITY_EN
            par_mem[wr_addr_i][b] <= (^wr_data_i[8*b +: 8]) ^ par_inj_i;
`endif
          end
        end
      end
    end
  end

  assign init_busy_o = init_busy_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

endmodule
